// File: rtl/layer_in_if.sv
// Byte-stream input and layer-buffer write bus of layer_in.
// Exposes err_cnt_out only when LAYER_IN_ERR_CNT_EN is defined.
interface layer_in_if #(
   parameter int unsigned LAYERS = 8
) ();
   logic              spi_cs_in;
   logic              byte_rdy_in;
   logic [7:0]        byte_data_in;
   logic [LAYERS-1:0] layer_en_out;
   logic [5:0]        wr_addr_out;
   logic [3:0]        byte_en_out;
   logic [7:0]        byte_data_out;
   logic              frame_rdy_out;
`ifdef LAYER_IN_ERR_CNT_EN
   logic [7:0]        err_cnt_out;
`endif

   // Byte source and write-bus consumer side.
   modport master (
      output spi_cs_in, byte_rdy_in, byte_data_in,
      input  layer_en_out, wr_addr_out, byte_en_out, byte_data_out, frame_rdy_out
`ifdef LAYER_IN_ERR_CNT_EN
      , input err_cnt_out
`endif
   );

   // Command parser side.
   modport slave (
      input  spi_cs_in, byte_rdy_in, byte_data_in,
      output layer_en_out, wr_addr_out, byte_en_out, byte_data_out, frame_rdy_out
`ifdef LAYER_IN_ERR_CNT_EN
      , output err_cnt_out
`endif
   );
endinterface

// File: rtl/layer_in.sv
// Command parser: decodes the SPI byte stream and scatters pixel bytes into the
// per-layer buffers, pulsing frame_rdy_out after the last byte of a frame.
// Optional abort counter enabled by defining LAYER_IN_ERR_CNT_EN.
module layer_in #(
   parameter int unsigned LAYERS      = 8,
   parameter int unsigned PIXELS      = 64,
   parameter int unsigned PIXEL_BYTES = 3
) (
   input logic        clk_in,
   input logic        rst_in,
   layer_in_if.slave  bus
);
   localparam logic [7:0]        CmdDataWr = 8'hDA;
   localparam logic [1:0]        LnLast    = 2'(PIXEL_BYTES - 1);
   localparam logic [5:0]        PixLast   = 6'(PIXELS - 1);
   localparam logic [3:0]        LyrLast   = 4'(LAYERS - 1);
   localparam logic [LAYERS-1:0] LyrOne    = LAYERS'(1);

   typedef enum logic [0:0] {StIdle, StData} state_e;

   state_e            state_q, state_d;
   logic [1:0]        ln_q, ln_d;
   logic [5:0]        pix_q, pix_d;
   logic [3:0]        lyr_q, lyr_d;
   logic [LAYERS-1:0] layer_en_q, layer_en_d;
   logic [5:0]        wr_addr_q, wr_addr_d;
   logic [3:0]        byte_en_q, byte_en_d;
   logic [7:0]        data_q, data_d;
   logic              last_q, last_d;
   logic              frame_rdy_q, frame_rdy_d;
`ifdef LAYER_IN_ERR_CNT_EN
   logic [7:0]        err_cnt_q, err_cnt_d;
`endif

   logic accept;
   assign accept = bus.byte_rdy_in & bus.spi_cs_in;

   // Next-state: command decode, pixel scatter and nested counter advance.
   always_comb begin
      state_d     = state_q;
      ln_d        = ln_q;
      pix_d       = pix_q;
      lyr_d       = lyr_q;
      layer_en_d  = layer_en_q;
      wr_addr_d   = wr_addr_q;
      byte_en_d   = 4'b0000;
      data_d      = data_q;
      last_d      = 1'b0;
      // last_q marks the cycle of the final strobe; frame_rdy follows it.
      frame_rdy_d = last_q;
`ifdef LAYER_IN_ERR_CNT_EN
      err_cnt_d   = err_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept && bus.byte_data_in == CmdDataWr) begin
               state_d = StData;
               ln_d    = 2'd0;
               pix_d   = 6'd0;
               lyr_d   = 4'd0;
`ifdef LAYER_IN_ERR_CNT_EN
               if (err_cnt_q == 8'hFF) err_cnt_d = 8'h00;
`endif
            end
         end
         StData: begin
            if (!bus.spi_cs_in) begin
               // Abort; any byte presented with cs low is dropped.
               state_d = StIdle;
               ln_d    = 2'd0;
               pix_d   = 6'd0;
               lyr_d   = 4'd0;
`ifdef LAYER_IN_ERR_CNT_EN
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
            end else if (bus.byte_rdy_in) begin
               byte_en_d  = 4'b0001 << ln_q;
               wr_addr_d  = pix_q;
               layer_en_d = LyrOne << lyr_q;
               data_d     = bus.byte_data_in;
               if (ln_q == LnLast) begin
                  ln_d = 2'd0;
                  if (pix_q == PixLast) begin
                     pix_d = 6'd0;
                     if (lyr_q == LyrLast) begin
                        lyr_d   = 4'd0;
                        last_d  = 1'b1;
                        state_d = StIdle;
                     end else begin
                        lyr_d = lyr_q + 4'd1;
                     end
                  end else begin
                     pix_d = pix_q + 6'd1;
                  end
               end else begin
                  ln_d = ln_q + 2'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         ln_q        <= 2'd0;
         pix_q       <= 6'd0;
         lyr_q       <= 4'd0;
         layer_en_q  <= '0;
         wr_addr_q   <= 6'd0;
         byte_en_q   <= 4'b0000;
         data_q      <= 8'h00;
         last_q      <= 1'b0;
         frame_rdy_q <= 1'b0;
`ifdef LAYER_IN_ERR_CNT_EN
         err_cnt_q   <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         ln_q        <= ln_d;
         pix_q       <= pix_d;
         lyr_q       <= lyr_d;
         layer_en_q  <= layer_en_d;
         wr_addr_q   <= wr_addr_d;
         byte_en_q   <= byte_en_d;
         data_q      <= data_d;
         last_q      <= last_d;
         frame_rdy_q <= frame_rdy_d;
`ifdef LAYER_IN_ERR_CNT_EN
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   assign bus.layer_en_out  = layer_en_q;
   assign bus.wr_addr_out   = wr_addr_q;
   assign bus.byte_en_out   = byte_en_q;
   assign bus.byte_data_out = data_q;
   assign bus.frame_rdy_out = frame_rdy_q;
`ifdef LAYER_IN_ERR_CNT_EN
   assign bus.err_cnt_out   = err_cnt_q;
`endif
endmodule

// File: doc/layer_in.md
Name: layer_in

Overview:
- Upstream command parser feeding the per-layer output stages.
- Consumes the already-synchronised byte stream from the SPI slave and decodes the command protocol.
- Scatters pixel bytes into the layer buffers: one-hot layer select, pixel address, one-hot byte lane and data.
- Pulses frame-ready once a complete multi-layer frame has been written, so the output stages start shifting.

Parameters:
- LAYERS, 8, number of layer outputs; valid 1..16.
- PIXELS, 64, pixels per layer; valid 1..64.
- PIXEL_BYTES, 3, bytes per pixel written to lanes 0..PIXEL_BYTES-1; valid 1..4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- spi_cs_in  input  1  chip select, already synchronised, active-high while a transfer is in progress.
- byte_rdy_in  input  1  single-cycle strobe: byte_data_in valid.
- byte_data_in  input  8  received SPI byte.
- layer_en_out  output  LAYERS  one-hot target layer, valid with byte_en_out.
- wr_addr_out  output  6  pixel index within the layer.
- byte_en_out  output  4  one-hot byte-lane write strobe; single-cycle.
- byte_data_out  output  8  write data.
- frame_rdy_out  output  1  single-cycle pulse: full frame written.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Reset is honoured in any state, including mid-frame, and no frame_rdy is produced for the partial frame.
- All outputs are registered.
- A byte is accepted only in a cycle where byte_rdy_in=1 and spi_cs_in=1.
- States:
  - IDLE: an accepted byte is decoded as a command.
  - DATA: accepted bytes are written as pixel data.
- Command 0xDA (DATA_WR), received in IDLE:
  - Clear layer counter (lyr), pixel counter (pix) and lane counter (ln).
  - Go to DATA.
  - No output strobe is produced for the command byte itself.
- Command 0x00 (NOP), and any other command value, in IDLE: ignored; stay in IDLE.
- DATA, per accepted byte: one cycle later the block drives
  - byte_en_out = 1<<ln,
  - wr_addr_out = pix,
  - layer_en_out = 1<<lyr,
  - byte_data_out = the byte.
  - byte_en_out returns to 0 the following cycle.
  - layer_en_out, wr_addr_out and byte_data_out hold their values until the next write.
- Counter advance, nested, all counters unsigned:
  - ln increments; at PIXEL_BYTES-1 it wraps to 0 and pix increments.
  - pix wraps at PIXELS-1 to 0 and lyr increments.
  - lyr wraps at LAYERS-1, which marks the last byte of the frame.
- Last byte of the frame (ln=PIXEL_BYTES-1, pix=PIXELS-1, lyr=LAYERS-1):
  - Its write strobe is issued normally.
  - frame_rdy_out pulses for exactly 1 cycle, in the cycle immediately after that strobe.
  - State returns to IDLE.
  - Total data bytes per frame = LAYERS*PIXELS*PIXEL_BYTES (1536 at defaults).
- Abort: spi_cs_in=0 in DATA returns to IDLE on the next clock.
  - Counters are cleared and no frame_rdy_out is produced.
  - A write strobe already in flight still completes.
- Simultaneous byte_rdy_in=1 and spi_cs_in=0: the byte is dropped.
- Bytes arriving in IDLE after a completed frame are decoded as commands again.
- Back-to-back byte_rdy_in on consecutive cycles must be accepted with no loss: one strobe per cycle, throughput 1 byte/clk.
- Lanes at or above PIXEL_BYTES are never strobed.

Optional Feature:
- Macro: LAYER_IN_ERR_CNT_EN.
- Defined: adds output port err_cnt_out (8 bits, reset 0).
  - Increments once per aborted DATA frame (spi_cs_in falls before the last byte).
  - Saturates at 255.
  - Cleared when a DATA_WR command is accepted while err_cnt_out=255.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: with rst_in high, all outputs are 0. After release, the NOP sequence 0x00, 0x55 produces no byte_en_out and no frame_rdy_out.
- Full frame, defaults: send 0xDA then 1536 bytes with value = index mod 256.
  - Byte 0 → layer_en=0x01, addr 0, byte_en=0x1.
  - Byte 3 → addr 1, byte_en=0x1.
  - Byte 192 → layer_en=0x02, addr 0.
  - Byte 1535 → layer_en=0x80, addr 63, byte_en=0x4, data 0xFF.
  - frame_rdy_out pulses once, 1 cycle after the last strobe.
- Back-to-back bytes: byte_rdy_in held high for 10 cycles after 0xDA → 10 consecutive single-cycle strobes with lanes 1,2,4,1,2,4,... and addresses 0,0,0,1,1,1,...
- Abort: spi_cs_in drops after 100 data bytes.
  - No frame_rdy_out.
  - A following 0xDA plus 1 byte writes layer 0, addr 0, lane 0.
  - With LAYER_IN_ERR_CNT_EN defined, err_cnt_out=1.
- Reset mid-frame: assert rst_in after 500 bytes → outputs 0 immediately (asynchronous); a subsequent full frame behaves as in the full-frame scenario.
- Parameter sweep: LAYERS=1, PIXELS=1, PIXEL_BYTES=4 → 0xDA plus 4 bytes gives lanes 0x1, 0x2, 0x4, 0x8 then frame_rdy_out; a 5th byte is treated as a command.
